// File: rtl/i2s_stereo_transmitter.sv
// Philips I2S stereo transmitter: converts offset-binary sample pairs to two's complement
// and serializes them MSB first, with a single-entry holding buffer behind valid/ready.
module i2s_stereo_transmitter #(
  parameter int unsigned DATA_WIDTH    = 16,
  parameter int unsigned SLOT_BITS     = 16,
  parameter int unsigned SCLK_DIV      = 4,
  parameter int unsigned OFFSET_BINARY = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [23:0] in_l,
  input  logic [23:0] in_r,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        sck,
  output logic        ws,
  output logic        sd,
  output logic        sample_req,
  output logic        underrun
);

  localparam int unsigned FRAME_BITS = 2 * SLOT_BITS;
  localparam int unsigned POS_W      = (FRAME_BITS > 2) ? $clog2(FRAME_BITS) : 1;
  localparam int unsigned DIV_W      = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
  localparam logic [DATA_WIDTH-1:0] TOP_BIT = DATA_WIDTH'(1) << (DATA_WIDTH - 1);
  localparam logic [DATA_WIDTH-1:0] CONV_MASK = (OFFSET_BINARY != 0) ? TOP_BIT : '0;

  logic [DIV_W-1:0]      div_cnt, div_cnt_nxt;
  logic                  sck_nxt;
  logic [POS_W-1:0]      pos, pos_nxt, pos_inc, slot_bit;
  logic                  ws_nxt, sd_nxt;
  logic [DATA_WIDTH-1:0] cur_l, cur_r, cur_l_nxt, cur_r_nxt;
  logic [DATA_WIDTH-1:0] hold_l, hold_r, hold_l_nxt, hold_r_nxt;
  logic                  hold_full, hold_full_nxt;
  logic                  in_ready_nxt, sample_req_nxt, underrun_nxt;
  logic [DATA_WIDTH-1:0] conv_l, conv_r, word;
  logic                  wrap, fe, xfer, accept;
  logic                  unused_in;

  // Upper sample bits beyond DATA_WIDTH are intentionally ignored.
  assign unused_in = ^{in_l, in_r};

  assign conv_l = in_l[DATA_WIDTH-1:0] ^ CONV_MASK;
  assign conv_r = in_r[DATA_WIDTH-1:0] ^ CONV_MASK;

  assign wrap   = (div_cnt == DIV_W'(SCLK_DIV - 1));
  assign fe     = wrap && sck;
  assign xfer   = fe && (pos == '0);
  assign accept = in_valid && in_ready;

  assign pos_inc  = (pos == POS_W'(FRAME_BITS - 1)) ? '0 : pos + POS_W'(1);
  // Bit index within the slot whose data is emitted after this falling edge.
  assign slot_bit = (pos >= POS_W'(SLOT_BITS)) ? pos - POS_W'(SLOT_BITS) : pos;

  // Next-state logic for divider, frame position, serializer and holding buffer.
  always_comb begin
    div_cnt_nxt    = wrap ? '0 : div_cnt + DIV_W'(1);
    sck_nxt        = wrap ? ~sck : sck;
    pos_nxt        = pos;
    ws_nxt         = ws;
    sd_nxt         = sd;
    cur_l_nxt      = cur_l;
    cur_r_nxt      = cur_r;
    hold_l_nxt     = hold_l;
    hold_r_nxt     = hold_r;
    hold_full_nxt  = hold_full;
    sample_req_nxt = 1'b0;
    underrun_nxt   = 1'b0;
    word           = '0;

    if (xfer) begin
      sample_req_nxt = 1'b1;
      if (hold_full) begin
        cur_l_nxt     = hold_l;
        cur_r_nxt     = hold_r;
        hold_full_nxt = 1'b0;
      end else begin
        cur_l_nxt    = '0;
        cur_r_nxt    = '0;
        underrun_nxt = 1'b1;
      end
    end

    if (accept) begin
      hold_l_nxt    = conv_l;
      hold_r_nxt    = conv_r;
      hold_full_nxt = 1'b1;
    end

    // ws leads the slot by one bit; sd uses the freshly transferred word at slot start.
    if (fe) begin
      pos_nxt = pos_inc;
      ws_nxt  = (pos_inc != POS_W'(FRAME_BITS - 1)) && (pos_inc >= POS_W'(SLOT_BITS - 1));
      word    = (pos < POS_W'(SLOT_BITS)) ? cur_l_nxt : cur_r_nxt;
      sd_nxt  = |(word & (TOP_BIT >> slot_bit));
    end

    in_ready_nxt = ~hold_full_nxt;
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt    <= '0;
      sck        <= 1'b0;
      pos        <= '0;
      ws         <= 1'b0;
      sd         <= 1'b0;
      cur_l      <= '0;
      cur_r      <= '0;
      hold_l     <= '0;
      hold_r     <= '0;
      hold_full  <= 1'b0;
      in_ready   <= 1'b1;
      sample_req <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      div_cnt    <= div_cnt_nxt;
      sck        <= sck_nxt;
      pos        <= pos_nxt;
      ws         <= ws_nxt;
      sd         <= sd_nxt;
      cur_l      <= cur_l_nxt;
      cur_r      <= cur_r_nxt;
      hold_l     <= hold_l_nxt;
      hold_r     <= hold_r_nxt;
      hold_full  <= hold_full_nxt;
      in_ready   <= in_ready_nxt;
      sample_req <= sample_req_nxt;
      underrun   <= underrun_nxt;
    end
  end

endmodule

// File: tb/tb_i2s_stereo_transmitter.sv
// Bench for i2s_stereo_transmitter: lane 0 uses 16-bit slots with offset-binary conversion,
// lane 1 uses 24-bit slots with pass-through; both checked every cycle against a frame-level model.
module tb_i2s_stereo_transmitter;

  localparam int unsigned DIV = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [23:0] in_l [2];
  logic [23:0] in_r [2];
  logic [1:0]  in_valid;
  logic [1:0]  in_ready_v, sck_v, ws_v, sd_v, sreq_v, urun_v;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int sr_cnt  [2] = '{0, 0};
  int ur_cnt  [2] = '{0, 0};
  int sr_last [2] = '{0, 0};
  int sr_gap  [2] = '{0, 0};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int g, input logic [47:0] act, input logic [47:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s lane%0d: got %0h expected %0h at %0t", name, g, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : lane
    localparam int unsigned DW = 16;
    localparam int unsigned SB = (g == 0) ? 16 : 24;
    localparam int unsigned OB = (g == 0) ? 1 : 0;

    i2s_stereo_transmitter #(
      .DATA_WIDTH(DW), .SLOT_BITS(SB), .SCLK_DIV(DIV), .OFFSET_BINARY(OB)
    ) dut (
      .clk(clk), .rst_n(rst_n), .in_l(in_l[g]), .in_r(in_r[g]), .in_valid(in_valid[g]),
      .in_ready(in_ready_v[g]), .sck(sck_v[g]), .ws(ws_v[g]), .sd(sd_v[g]),
      .sample_req(sreq_v[g]), .underrun(urun_v[g])
    );

    function automatic logic [23:0] conv(input logic [23:0] x);
      logic [23:0] y;
      y = x & ((24'h1 << DW) - 24'h1);
      if (OB != 0) y = y ^ (24'h1 << (DW - 1));
      return y;
    endfunction

    // Timeline model: everything follows from t = clk edges since reset release.
    initial begin : model
      int t, nfe, pos, f, q, k;
      bit hf, xfer, acc;
      logic [23:0] hl, hr, word;
      logic [23:0] fl [$];
      logic [23:0] fr [$];
      bit fu [$];
      bit e_sck, e_ws, e_sd, e_rdy, e_req, e_ur;
      t = 0; hf = 1'b0; hl = '0; hr = '0;
      forever begin
        @(posedge clk);
        #1;
        if (sreq_v[g]) begin
          sr_cnt[g]++;
          sr_gap[g]  = cyc - sr_last[g];
          sr_last[g] = cyc;
        end
        if (urun_v[g]) ur_cnt[g]++;
        if (!rst_n) begin
          t = 0; hf = 1'b0;
          fl.delete(); fr.delete(); fu.delete();
          e_sck = 0; e_ws = 0; e_sd = 0; e_rdy = 1; e_req = 0; e_ur = 0;
        end else begin
          t++;
          nfe  = t / (2 * DIV);
          xfer = (t % (2 * DIV) == 0) && (nfe % (2 * SB) == 1);
          acc  = in_valid[g] && !hf;
          if (xfer) begin
            fl.push_back(hf ? hl : 24'h0);
            fr.push_back(hf ? hr : 24'h0);
            fu.push_back(!hf);
            hf = 1'b0;
          end
          if (acc) begin
            hl = conv(in_l[g]);
            hr = conv(in_r[g]);
            hf = 1'b1;
          end
          e_sck = ((t / DIV) % 2) == 1;
          pos   = nfe % (2 * SB);
          e_ws  = ((pos + 1) % (2 * SB)) >= SB;
          e_sd  = 1'b0;
          if (nfe > 0) begin
            f    = (nfe - 1) / (2 * SB);
            q    = (nfe - 1) % (2 * SB);
            word = (q < SB) ? fl[f] : fr[f];
            k    = q % SB;
            if (k < DW) e_sd = word[DW-1-k];
          end
          e_rdy = !hf;
          e_req = xfer;
          e_ur  = xfer && fu[$];
        end
        chk("sck", g, 48'(sck_v[g]), 48'(e_sck));
        chk("ws", g, 48'(ws_v[g]), 48'(e_ws));
        chk("sd", g, 48'(sd_v[g]), 48'(e_sd));
        chk("in_ready", g, 48'(in_ready_v[g]), 48'(e_rdy));
        chk("sample_req", g, 48'(sreq_v[g]), 48'(e_req));
        chk("underrun", g, 48'(urun_v[g]), 48'(e_ur));
      end
    end
  end

  task automatic wait_req(input int g, input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      if (sreq_v[g]) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      n_cmp++;
      n_err++;
      $display("FAIL wait_req lane%0d: got no sample_req expected one within %0d cycles", g, limit);
    end
  endtask

  task automatic send(input int g, input logic [23:0] l, input logic [23:0] r,
                      output int waited, output bit req_seen);
    in_l[g] = l;
    in_r[g] = r;
    in_valid[g] = 1'b1;
    waited = 0;
    while (!in_ready_v[g] && waited < 400) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready_v[g]) begin
      n_cmp++;
      n_err++;
      $display("FAIL send lane%0d: got in_ready=0 expected 1 within %0d cycles", g, waited);
    end
    req_seen = sreq_v[g];
    @(negedge clk);
    in_valid[g] = 1'b0;
  endtask

  initial begin
    int w;
    bit rq, ok;
    int ur0, ur1, sr0;
    logic [31:0] cap0;
    logic [47:0] cap1;

    rst_n = 1'b1;
    in_valid = '0;
    in_l = '{24'h0, 24'h0};
    in_r = '{24'h0, 24'h0};
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_in_ready", 0, 48'(in_ready_v[0]), 48'd1);
    chk("reset_sck", 0, 48'(sck_v[0]), 48'd0);
    chk("reset_ws", 0, 48'(ws_v[0]), 48'd0);
    chk("reset_sd", 0, 48'(sd_v[0]), 48'd0);

    // Idle: silence, one underrun per frame.
    ur0 = ur_cnt[0]; ur1 = ur_cnt[1]; sr0 = sr_cnt[0];
    rst_n = 1'b1;
    repeat (400) @(negedge clk);
    chk("idle_underruns", 0, 48'(ur_cnt[0] - ur0), 48'd4);
    chk("idle_underruns", 1, 48'(ur_cnt[1] - ur1), 48'd3);
    chk("idle_req_count", 0, 48'(sr_cnt[0] - sr0), 48'd4);
    chk("frame_period", 0, 48'(sr_gap[0]), 48'd128);
    chk("frame_period", 1, 48'(sr_gap[1]), 48'd192);

    // First pair accepted before the first falling event.
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    in_l[0] = 24'h008001; in_r[0] = 24'h007FFF;
    in_l[1] = 24'h00A5C3; in_r[1] = 24'h00FF00;
    in_valid = 2'b11;
    @(negedge clk);
    in_valid = 2'b00;
    chk("accept_drops_ready", 0, 48'(in_ready_v[0]), 48'd0);
    chk("accept_drops_ready", 1, 48'(in_ready_v[1]), 48'd0);
    wait_req(0, 20, ok);
    chk("first_frame_underrun", 0, 48'(urun_v[0]), 48'd0);
    chk("first_frame_underrun", 1, 48'(urun_v[1]), 48'd0);
    cap0 = '0;
    cap1 = '0;
    for (int i = 0; i < 48; i++) begin
      if (i < 32) cap0 = {cap0[30:0], sd_v[0]};
      cap1 = {cap1[46:0], sd_v[1]};
      repeat (2 * DIV) @(negedge clk);
    end
    chk("frame_words", 0, 48'(cap0), 48'h0000_0001_FFFF);
    chk("frame_words", 1, cap1, 48'hA5C300_FF0000);

    // Idle-value samples every frame: silent output, no underrun.
    send(0, 24'h008000, 24'h008000, w, rq);
    ur0 = ur_cnt[0]; sr0 = sr_cnt[0];
    for (int i = 0; i < 3; i++) send(0, 24'h008000, 24'h008000, w, rq);
    chk("busy_underruns", 0, 48'(ur_cnt[0] - ur0), 48'd0);
    chk("busy_reqs", 0, 48'(sr_cnt[0] - sr0), 48'd3);

    // Back-to-back pairs: B stalls until A moves into the shifter.
    send(0, 24'h001234, 24'h00ABCD, w, rq);
    send(0, 24'h000F0F, 24'h00F0F0, w, rq);
    chk("b2b_stalled", 0, 48'(w > 0), 48'd1);
    chk("b2b_accept_with_req", 0, 48'(rq), 48'd1);
    wait_req(0, 200, ok);
    chk("b2b_underrun", 0, 48'(urun_v[0]), 48'd0);
    cap0 = '0;
    for (int i = 0; i < 32; i++) begin
      cap0 = {cap0[30:0], sd_v[0]};
      repeat (2 * DIV) @(negedge clk);
    end
    chk("b2b_words", 0, 48'(cap0), 48'h0000_8F0F_70F0);

    // Reset at pos 20 with a pair held: the pair must be dropped.
    send(0, 24'h00AAAA, 24'h005555, w, rq);
    repeat (75) @(negedge clk);
    chk("pre_reset_ws", 0, 48'(ws_v[0]), 48'd1);
    chk("pre_reset_ready", 0, 48'(in_ready_v[0]), 48'd0);
    rst_n = 1'b0;
    #1;
    chk("async_sck", 0, 48'(sck_v[0]), 48'd0);
    chk("async_ws", 0, 48'(ws_v[0]), 48'd0);
    chk("async_sd", 0, 48'(sd_v[0]), 48'd0);
    chk("async_ready", 0, 48'(in_ready_v[0]), 48'd1);
    chk("async_req", 0, 48'(sreq_v[0]), 48'd0);
    chk("async_underrun", 0, 48'(urun_v[0]), 48'd0);
    ur0 = ur_cnt[0]; sr0 = sr_cnt[0];
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (250) @(negedge clk);
    chk("post_reset_underruns", 0, 48'(ur_cnt[0] - ur0), 48'd2);
    chk("post_reset_reqs", 0, 48'(sr_cnt[0] - sr0), 48'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
